// File: rtl/playback_vector_engine.sv
// playback_vector_engine: replays stored stimulus vectors into a DUT and checks its responses against masked expected vectors
module playback_vector_engine #(
    parameter int IN_W   = 43,
    parameter int OUT_W  = 39,
    parameter int ADDR_W = 10,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [IN_W-1:0]   ld_stim,
    input  logic [OUT_W-1:0]  ld_exp,
    input  logic [OUT_W-1:0]  ld_mask,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              stop_on_fail,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              first_fail_vld,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [OUT_W-1:0]  fail_bits
);
    localparam int W = IN_W + 2 * OUT_W;
    localparam logic [LAT:0] TOP = (LAT + 1)'(1) << LAT;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [W-1:0]      mem [2**ADDR_W];
    logic [W-1:0]      rd_q;
    logic              rd_v_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic [ADDR_W:0]   addr_q, num_q;
    logic              sof_q;
    logic [LAT:0]      pv_q;
    logic [OUT_W-1:0]  pexp_q  [LAT+1];
    logic [OUT_W-1:0]  pmask_q [LAT+1];
    logic [ADDR_W-1:0] pidx_q  [LAT+1];
    logic [IN_W-1:0]   dut_in_q;
    logic              pass_q, ffv_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ffidx_q;
    logic [OUT_W-1:0]  fb_q, diff;
    logic              idle_like, go, mm, halt, issue, rd_en, last, drained;

    always_comb begin
        idle_like = (state_q == IDLE) || (state_q == DONE);
        go        = start && idle_like;
        diff      = pv_q[LAT] ? (dut_out ^ pexp_q[LAT]) & pmask_q[LAT] : '0;
        mm        = |diff;
        halt      = sof_q && mm;
        // a mismatch under stop-on-fail squashes the vector already read but not yet driven
        issue     = rd_v_q && !halt;
        rd_en     = (state_q == RUN) && !halt;
        last      = addr_q == num_q - 1'b1;
        drained   = !issue && !(|(pv_q & ~TOP));
        cnt_d     = (mm && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dut_in_q <= '0;
            rd_v_q   <= 1'b0;
            pv_q     <= '0;
            addr_q   <= '0;
            num_q    <= '0;
            sof_q    <= 1'b0;
            pass_q   <= 1'b0;
            cnt_q    <= '0;
            ffv_q    <= 1'b0;
            ffidx_q  <= '0;
            fb_q     <= '0;
        end else begin
            rd_v_q <= rd_en;
            pv_q   <= (LAT + 1)'({pv_q, issue});
            cnt_q  <= cnt_d;
            fb_q   <= fb_q | diff;
            if (issue) dut_in_q <= rd_q[W-1 -: IN_W];
            if (rd_en) addr_q <= addr_q + 1'b1;
            if (mm && !ffv_q) begin
                ffv_q   <= 1'b1;
                ffidx_q <= pidx_q[LAT];
            end
            if (go) begin
                state_q <= (num_vec == '0) ? DONE : RUN;
                pass_q  <= num_vec == '0;
                addr_q  <= '0;
                num_q   <= num_vec;
                sof_q   <= stop_on_fail;
                cnt_q   <= '0;
                ffv_q   <= 1'b0;
                ffidx_q <= '0;
                fb_q    <= '0;
            end else if (state_q == RUN && (halt || last)) begin
                state_q <= DRAIN;
            end else if (state_q == DRAIN && drained) begin
                state_q <= DONE;
                pass_q  <= cnt_d == '0;
            end
        end
    end

    // store and compare payload carry no reset; validity lives in rd_v_q/pv_q
    always_ff @(posedge clk) begin
        if (ld_valid && idle_like && !start) mem[ld_addr] <= {ld_stim, ld_exp, ld_mask};
        if (rd_en) begin
            rd_q     <= mem[addr_q[ADDR_W-1:0]];
            rd_idx_q <= addr_q[ADDR_W-1:0];
        end
        if (issue) begin
            pexp_q[0]  <= rd_q[OUT_W +: OUT_W];
            pmask_q[0] <= rd_q[OUT_W-1:0];
            pidx_q[0]  <= rd_idx_q;
        end
        for (int j = 1; j <= LAT; j++) begin
            pexp_q[j]  <= pexp_q[j-1];
            pmask_q[j] <= pmask_q[j-1];
            pidx_q[j]  <= pidx_q[j-1];
        end
    end

    assign dut_in         = dut_in_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = state_q == DONE;
    assign pass           = pass_q;
    assign mismatch_cnt   = cnt_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffidx_q;
    assign fail_bits      = fb_q;
endmodule
